// File: rtl/spmv_pkg.sv
// Shared types and constants for the SpMV read-address sequencer.
//   state_t    : sequencer FSM states
//   DEF_*      : default widths used by the sequencer parameters
//   ADDR_IDLE  : address value presented whenever no sequence is active
package spmv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRIME,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam int DEF_ADDR_WIDTH  = 32;
   localparam int DEF_COUNT_WIDTH = 32;
   localparam int DEF_PASS_WIDTH  = 8;

   localparam logic [DEF_ADDR_WIDTH-1:0] ADDR_IDLE = '1;

endpackage

// File: rtl/preprocess_delay_line.sv
// Fixed-depth delay for the accepted-advance strobe.
//   clk     : rising-edge clock
//   reset   : asynchronous active-low clear
//   flush   : synchronous clear of every stage
//   strobe  : strobe entering the line
//   delayed : strobe exactly DEPTH cycles later
module preprocess_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic flush,
   input  logic strobe,
   output logic delayed
);

   logic [DEPTH:1] vld_pipe;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_pipe <= '0;
      end else if (flush) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[1] <= strobe;
         for (int i = 2; i <= DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   assign delayed = vld_pipe[DEPTH];

endmodule

// File: rtl/spmv_fetch_sequencer.sv
// Read-address sequencer for the SpMV datapath. One address register drives
// the memA, col_nos and multiples read ports in lock-step; every accepted
// advance steps it and, PREPROCESS_DELAY cycles later, raises
// memories_preprocess. Supports multi-pass wrap, ready gating and abort.
//   clk, reset              : clock, async active-low reset
//   start, abort            : begin sequence (from IDLE) / flush to IDLE
//   base_address, total_reads, num_passes : config, sampled on accepted start
//   gate_on_ready, ready_in : optional all-channels-ready gating of advance
//   pre_preprocess          : advance request (honoured only in RUN)
//   *_read_address          : shared read address
//   memories_preprocess     : delayed accepted-advance strobe
//   busy, done, pass_index  : status
module spmv_fetch_sequencer
   import spmv_pkg::*;
#(
   parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
   parameter int COUNT_WIDTH      = DEF_COUNT_WIDTH,
   parameter int PASS_WIDTH       = DEF_PASS_WIDTH,
   parameter int NO_OF_CHANNELS   = 4,
   parameter int PREPROCESS_DELAY = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      abort,
   input  logic [ADDR_WIDTH-1:0]     base_address,
   input  logic [COUNT_WIDTH-1:0]    total_reads,
   input  logic [PASS_WIDTH-1:0]     num_passes,
   input  logic                      gate_on_ready,
   input  logic                      pre_preprocess,
   input  logic [NO_OF_CHANNELS-1:0] ready_in,
   output logic [ADDR_WIDTH-1:0]     memA_read_address,
   output logic [ADDR_WIDTH-1:0]     col_nos_read_address,
   output logic [ADDR_WIDTH-1:0]     multiples_read_address,
   output logic                      memories_preprocess,
   output logic                      busy,
   output logic                      done,
   output logic [PASS_WIDTH-1:0]     pass_index
);

   localparam logic [ADDR_WIDTH-1:0]  ADDR_ONES  = '1;
   localparam logic [COUNT_WIDTH-1:0] DRAIN_LAST = COUNT_WIDTH'(PREPROCESS_DELAY - 1);

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   addr, base_q;
   logic [COUNT_WIDTH-1:0]  total_q, cnt, cnt_nxt;
   logic [PASS_WIDTH-1:0]   last_pass_q, pass_q, pass_nxt;
   logic                    wrap_q;   // pass finished; next advance restarts at base
   logic                    advance, pass_end, last_adv, drain_end;

   // Abort suppresses the advance so the strobe count never includes it.
   assign advance   = pre_preprocess & (state == ST_RUN) & ~abort &
                      (~gate_on_ready | (&ready_in));
   assign cnt_nxt   = (wrap_q ? '0 : cnt) + COUNT_WIDTH'(1);
   assign pass_nxt  = wrap_q ? pass_q + PASS_WIDTH'(1) : pass_q;
   assign pass_end  = (cnt_nxt == total_q);
   assign last_adv  = advance & pass_end & (pass_nxt == last_pass_q);
   // In DRAIN the advance counter is reused as the drain timer.
   assign drain_end = (cnt == DRAIN_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      if (abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (start) state_nxt = (total_reads == '0) ? ST_DRAIN : ST_PRIME;
            ST_PRIME: state_nxt = ST_RUN;
            ST_RUN:   if (last_adv) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_end) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
         endcase
      end
      case (state)
         ST_PRIME, ST_RUN, ST_DRAIN: busy = 1'b1;
         ST_DONE:                    done = 1'b1;
         default:                    ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr        <= ADDR_ONES;
         base_q      <= '0;
         total_q     <= '0;
         last_pass_q <= '0;
         cnt         <= '0;
         pass_q      <= '0;
         wrap_q      <= 1'b0;
      end else if (abort) begin
         addr   <= ADDR_ONES;
         cnt    <= '0;
         pass_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               base_q      <= base_address;
               total_q     <= total_reads;
               last_pass_q <= (num_passes == '0) ? '0 : num_passes - PASS_WIDTH'(1);
               // One below base so the first advance lands on base.
               addr        <= base_address - ADDR_WIDTH'(1);
               cnt         <= '0;
               pass_q      <= '0;
               wrap_q      <= 1'b0;
            end
            ST_RUN: if (advance) begin
               addr   <= wrap_q ? base_q : addr + ADDR_WIDTH'(1);
               cnt    <= last_adv ? '0 : cnt_nxt;
               pass_q <= pass_nxt;
               wrap_q <= pass_end & ~last_adv;
            end
            ST_DRAIN: cnt <= cnt + COUNT_WIDTH'(1);
            ST_DONE: begin
               addr   <= ADDR_ONES;
               cnt    <= '0;
               pass_q <= '0;
            end
            default: ;
         endcase
      end
   end

   assign memA_read_address      = addr;
   assign col_nos_read_address   = addr;
   assign multiples_read_address = addr;
   assign pass_index             = pass_q;

   preprocess_delay_line #(.DEPTH(PREPROCESS_DELAY)) u_delay (
      .clk     (clk),
      .reset   (reset),
      .flush   (abort),
      .strobe  (advance),
      .delayed (memories_preprocess)
   );

endmodule
